// File: rtl/dser_pkg.sv
// Shared types and line levels for the dser_tx serial frame transmitter.
package dser_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} dser_state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
endpackage

// File: rtl/dser_tick.sv
// Bit-period divider: tick marks the last clk50m cycle of every serial bit.
module dser_tick #(
  parameter int CLKDIV = 4
) (
  input  logic clk50m,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int            CW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk50m) begin
    if (rst || !en)         r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick = en && (r_cnt == LAST);
endmodule

// File: rtl/dser_tx.sv
// Parallel-in/serial-out transmitter: start bit, W data bits MSB first, stop bit.
module dser_tx
  import dser_pkg::*;
#(
  parameter int W      = 16,
  parameter int CLKDIV = 4
) (
  input  logic         clk50m,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         ready,
  output logic         busy,
  output logic         sdo,
  output logic         done
);
  localparam int            BW      = $clog2(W + 1);
  localparam logic [BW-1:0] LASTBIT = BW'(W - 1);

  dser_state_t   r_state, w_nstate;
  logic [W-1:0]  r_shreg, w_nshreg;
  logic [BW-1:0] r_bitcnt, w_nbitcnt;
  logic          r_sdo, w_nsdo;
  logic          w_en, w_tick, w_fin, w_accept;

  assign w_en = (r_state != IDLE);

  dser_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk50m (clk50m),
    .rst    (rst),
    .en     (w_en),
    .tick   (w_tick)
  );

  // The last stop-bit cycle doubles as the done/ready cycle, so a word offered
  // then starts its start bit immediately with no idle gap. Only flops feed these.
  assign w_fin    = (r_state == STOP) && w_tick;
  assign ready    = (r_state == IDLE) || w_fin;
  assign busy     = !ready;
  assign done     = w_fin;
  assign sdo      = r_sdo;
  assign w_accept = load && ready;

  always_comb begin
    w_nstate  = r_state;
    w_nshreg  = r_shreg;
    w_nbitcnt = r_bitcnt;
    case (r_state)
      IDLE:  ;
      START: if (w_tick) w_nstate = DATA;
      DATA:  if (w_tick) begin
        w_nshreg  = r_shreg << 1;
        w_nbitcnt = r_bitcnt + BW'(1);
        if (r_bitcnt == LASTBIT) w_nstate = STOP;
      end
      STOP:  if (w_tick) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
    if (w_accept) begin
      w_nstate  = START;
      w_nshreg  = d;
      w_nbitcnt = '0;
    end
    // sdo is registered from the next state so it lines up with the state it shows
    case (w_nstate)
      IDLE:    w_nsdo = IDLE_LVL;
      START:   w_nsdo = START_LVL;
      DATA:    w_nsdo = w_nshreg[W-1];
      default: w_nsdo = STOP_LVL;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_sdo    <= IDLE_LVL;
    end else begin
      r_state  <= w_nstate;
      r_shreg  <= w_nshreg;
      r_bitcnt <= w_nbitcnt;
      r_sdo    <= w_nsdo;
    end
  end
endmodule
